render_state_sequencer: RTL and testbench
=========================================

Name: render_state_sequencer

Overview:
- Frame-synchronous controller in front of the render coordinate-transform path.
- Owns the game-state FSM (IDLE / GAMING / WIN / LOSE) and drives the is-gaming and game-state inputs of the render path.
- Snapshots all player and bullet render attributes once per frame, at the frame-start pulse, so the per-pixel render logic never sees mid-frame (tearing) updates.
- Issues a one-cycle round-start pulse to game logic.

Parameters:
- MAP_H_WIDTH, 10, width of horizontal coordinates (signed x).
- MAP_V_WIDTH, 9, width of vertical coordinates (signed y).
- HP_WIDTH, 4, width of hit-point values.
- RESULT_HOLD_FRAMES, 120, minimum frames WIN/LOSE is shown before start is accepted.
- FCNT_WIDTH, 8, width of frame counter; must hold RESULT_HOLD_FRAMES.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse at first cycle of vertical blanking.
- i_start  in  1  start button, level, already debounced/synchronised.
- i_p1_x, i_p2_x  in  MAP_H_WIDTH  live signed player x.
- i_p1_y, i_p2_y  in  MAP_V_WIDTH  live signed player y.
- i_p1_hp, i_p2_hp  in  HP_WIDTH  live hit points.
- i_p1_shield, i_p1_squat, i_p2_shield, i_p2_squat  in  1  live pose flags.
- i_b1_x, i_b2_x  in  MAP_H_WIDTH  live bullet x.
- i_b1_y, i_b2_y  in  MAP_V_WIDTH  live bullet y.
- i_b1_valid, i_b2_valid  in  1  live bullet valid.
- o_p1_x … o_b2_valid  out  same as inputs  frame-latched copies of every input above, same names with o_ prefix.
- o_is_gaming  out  1  high in GAMING.
- o_game_state  out  2  00 IDLE, 01 GAMING, 10 WIN, 11 LOSE.
- o_round_start  out  1  one-cycle pulse on entry to GAMING.
- o_frame_cnt  out  FCNT_WIDTH  frames elapsed in the current state (saturating).

Behaviour:
- Reset (async assert, sync release): state IDLE; all o_ snapshot outputs 0; o_is_gaming 0; o_round_start 0; o_frame_cnt 0; start-edge register 0; start_pending 0.
- Start edge: start_rise = i_start & ~start_q, with start_q registered every cycle.
- Start latching in IDLE: start_rise sets start_pending. start_pending clears on the next frame boundary.
- Commit points: state transitions and snapshot updates occur only on cycles with i_frame_start=1. Registered outputs change on the following edge, so latency is 1 cycle from the frame pulse. Between pulses every output holds.
- FSM, evaluated on i_frame_start:
  - IDLE: if start_pending or start_rise → GAMING, and o_round_start=1 for exactly that one cycle.
  - GAMING: if i_p1_hp==0 → LOSE; else if i_p2_hp==0 → WIN; else stay. If both are zero in the same frame → LOSE (player-1 loss has priority).
  - WIN/LOSE: if o_frame_cnt ≥ RESULT_HOLD_FRAMES and (start_rise, or i_start held high) → IDLE. Otherwise stay.
- Start outside the commit cycle:
  - start_rise while in WIN/LOSE before the hold expires is ignored; it is not latched.
  - start_rise while in GAMING is ignored.
- o_frame_cnt:
  - Cleared to 0 on the commit cycle of any state change.
  - Otherwise incremented by 1 on each i_frame_start, saturating at all-ones.
- o_is_gaming = (state==GAMING), registered together with o_game_state so both always agree.
- Snapshot contents on i_frame_start:
  - All positions, hp and pose flags copy the live inputs.
  - o_b1_valid/o_b2_valid = live valid AND (next state == GAMING). Bullets are never shown outside a round, including on the frame that transitions to WIN/LOSE.
  - Snapshot uses the values present on the pulse cycle.
- Coincident events: i_frame_start with start_rise in IDLE → immediate transition; start_pending is not left set.
- Reset mid-frame or mid-round returns to IDLE at once, regardless of i_frame_start.
- Widths: straight register copies, no arithmetic on coordinates; signedness preserved.

Test Plan:
- Reset, then 3 frame pulses with live p1_x=25, p2_hp=5 → outputs stay 0 / state 00 until the first pulse; after the pulse o_p1_x=25, o_game_state=00, o_is_gaming=0.
- In IDLE, pulse i_start 100 cycles before i_frame_start → at the frame pulse o_round_start high for 1 cycle; next cycle o_game_state=01, o_is_gaming=1, o_frame_cnt=0.
- In GAMING, change i_p1_x from 10 to 40 mid-frame → o_p1_x stays 10 until the next i_frame_start, then becomes 40 one cycle later.
- In GAMING, set p1_hp=0 and p2_hp=0 together, with b1_valid=1 → after the pulse state=11 (LOSE), o_b1_valid=0, o_frame_cnt=0.
- In WIN with RESULT_HOLD_FRAMES=4, press start at frame 2 → ignored. Hold i_start high at frame 4 → state 00 after that pulse.
- In GAMING, assert i_rst_n=0 mid-frame, no frame pulse → all outputs 0 and state 00 immediately; start_pending 0.

Source files
------------

// File: rtl/render_state_sequencer.sv
// Frame-synchronous game-state FSM and render-attribute snapshot.
// Every output is a register that only changes on the edge after an i_frame_start pulse.
module render_state_sequencer #(
  parameter int MAP_H_WIDTH        = 10,
  parameter int MAP_V_WIDTH        = 9,
  parameter int HP_WIDTH           = 4,
  parameter int RESULT_HOLD_FRAMES = 120,
  parameter int FCNT_WIDTH         = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_frame_start,
  input  logic                          i_start,
  input  logic signed [MAP_H_WIDTH-1:0] i_p1_x,
  input  logic signed [MAP_H_WIDTH-1:0] i_p2_x,
  input  logic signed [MAP_V_WIDTH-1:0] i_p1_y,
  input  logic signed [MAP_V_WIDTH-1:0] i_p2_y,
  input  logic        [HP_WIDTH-1:0]    i_p1_hp,
  input  logic        [HP_WIDTH-1:0]    i_p2_hp,
  input  logic                          i_p1_shield,
  input  logic                          i_p1_squat,
  input  logic                          i_p2_shield,
  input  logic                          i_p2_squat,
  input  logic signed [MAP_H_WIDTH-1:0] i_b1_x,
  input  logic signed [MAP_H_WIDTH-1:0] i_b2_x,
  input  logic signed [MAP_V_WIDTH-1:0] i_b1_y,
  input  logic signed [MAP_V_WIDTH-1:0] i_b2_y,
  input  logic                          i_b1_valid,
  input  logic                          i_b2_valid,
  output logic signed [MAP_H_WIDTH-1:0] o_p1_x,
  output logic signed [MAP_H_WIDTH-1:0] o_p2_x,
  output logic signed [MAP_V_WIDTH-1:0] o_p1_y,
  output logic signed [MAP_V_WIDTH-1:0] o_p2_y,
  output logic        [HP_WIDTH-1:0]    o_p1_hp,
  output logic        [HP_WIDTH-1:0]    o_p2_hp,
  output logic                          o_p1_shield,
  output logic                          o_p1_squat,
  output logic                          o_p2_shield,
  output logic                          o_p2_squat,
  output logic signed [MAP_H_WIDTH-1:0] o_b1_x,
  output logic signed [MAP_H_WIDTH-1:0] o_b2_x,
  output logic signed [MAP_V_WIDTH-1:0] o_b1_y,
  output logic signed [MAP_V_WIDTH-1:0] o_b2_y,
  output logic                          o_b1_valid,
  output logic                          o_b2_valid,
  output logic                          o_is_gaming,
  output logic        [1:0]             o_game_state,
  output logic                          o_round_start,
  output logic        [FCNT_WIDTH-1:0]  o_frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GAMING = 2'b01,
    ST_WIN    = 2'b10,
    ST_LOSE   = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic                  start_q;
  logic                  start_pending_q;
  logic                  is_gaming_q;
  logic                  round_start_q;
  logic [FCNT_WIDTH-1:0] frame_cnt_q;
  logic                  start_rise;
  logic                  hold_done;

  assign start_rise = i_start & ~start_q;
  assign hold_done  = (frame_cnt_q >= FCNT_WIDTH'(RESULT_HOLD_FRAMES));

  // Next state as it would be committed if this cycle carries the frame pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_pending_q || start_rise) state_d = ST_GAMING;
        else                               state_d = ST_IDLE;
      end
      ST_GAMING: begin
        if (i_p1_hp == '0)      state_d = ST_LOSE;
        else if (i_p2_hp == '0) state_d = ST_WIN;
        else                    state_d = ST_GAMING;
      end
      ST_WIN, ST_LOSE: begin
        if (hold_done && (start_rise || i_start)) state_d = ST_IDLE;
        else                                      state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, frame counter and snapshot registers; all commits gated by the frame pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      start_q         <= 1'b0;
      start_pending_q <= 1'b0;
      is_gaming_q     <= 1'b0;
      round_start_q   <= 1'b0;
      frame_cnt_q     <= '0;
      o_p1_x          <= '0;
      o_p2_x          <= '0;
      o_p1_y          <= '0;
      o_p2_y          <= '0;
      o_p1_hp         <= '0;
      o_p2_hp         <= '0;
      o_p1_shield     <= 1'b0;
      o_p1_squat      <= 1'b0;
      o_p2_shield     <= 1'b0;
      o_p2_squat      <= 1'b0;
      o_b1_x          <= '0;
      o_b2_x          <= '0;
      o_b1_y          <= '0;
      o_b2_y          <= '0;
      o_b1_valid      <= 1'b0;
      o_b2_valid      <= 1'b0;
    end else begin
      start_q       <= i_start;
      round_start_q <= 1'b0;
      if (i_frame_start) begin
        state_q         <= state_d;
        is_gaming_q     <= (state_d == ST_GAMING);
        round_start_q   <= (state_q == ST_IDLE) && (state_d == ST_GAMING);
        start_pending_q <= 1'b0;
        if (state_d != state_q)  frame_cnt_q <= '0;
        else if (!(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + FCNT_WIDTH'(1);
        else                      frame_cnt_q <= frame_cnt_q;
        o_p1_x      <= i_p1_x;
        o_p2_x      <= i_p2_x;
        o_p1_y      <= i_p1_y;
        o_p2_y      <= i_p2_y;
        o_p1_hp     <= i_p1_hp;
        o_p2_hp     <= i_p2_hp;
        o_p1_shield <= i_p1_shield;
        o_p1_squat  <= i_p1_squat;
        o_p2_shield <= i_p2_shield;
        o_p2_squat  <= i_p2_squat;
        o_b1_x      <= i_b1_x;
        o_b2_x      <= i_b2_x;
        o_b1_y      <= i_b1_y;
        o_b2_y      <= i_b2_y;
        // Bullets are hidden on any frame that does not end up in a round.
        o_b1_valid  <= i_b1_valid & (state_d == ST_GAMING);
        o_b2_valid  <= i_b2_valid & (state_d == ST_GAMING);
      end else if ((state_q == ST_IDLE) && start_rise) begin
        start_pending_q <= 1'b1;
      end else begin
        start_pending_q <= start_pending_q;
      end
    end
  end

  assign o_game_state  = state_q;
  assign o_is_gaming   = is_gaming_q;
  assign o_round_start = round_start_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_render_state_sequencer.sv
// Directed bench for render_state_sequencer with a short result hold (4 frames).
module tb_render_state_sequencer;

  logic              i_clk = 1'b0;
  logic              i_rst_n, i_frame_start, i_start;
  logic signed [9:0] i_p1_x, i_p2_x, i_b1_x, i_b2_x;
  logic signed [8:0] i_p1_y, i_p2_y, i_b1_y, i_b2_y;
  logic        [3:0] i_p1_hp, i_p2_hp;
  logic              i_p1_shield, i_p1_squat, i_p2_shield, i_p2_squat;
  logic              i_b1_valid, i_b2_valid;
  logic signed [9:0] o_p1_x, o_p2_x, o_b1_x, o_b2_x;
  logic signed [8:0] o_p1_y, o_p2_y, o_b1_y, o_b2_y;
  logic        [3:0] o_p1_hp, o_p2_hp;
  logic              o_p1_shield, o_p1_squat, o_p2_shield, o_p2_squat;
  logic              o_b1_valid, o_b2_valid, o_is_gaming, o_round_start;
  logic        [1:0] o_game_state;
  logic        [7:0] o_frame_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  render_state_sequencer #(.RESULT_HOLD_FRAMES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start), .i_start(i_start),
    .i_p1_x(i_p1_x), .i_p2_x(i_p2_x), .i_p1_y(i_p1_y), .i_p2_y(i_p2_y),
    .i_p1_hp(i_p1_hp), .i_p2_hp(i_p2_hp),
    .i_p1_shield(i_p1_shield), .i_p1_squat(i_p1_squat),
    .i_p2_shield(i_p2_shield), .i_p2_squat(i_p2_squat),
    .i_b1_x(i_b1_x), .i_b2_x(i_b2_x), .i_b1_y(i_b1_y), .i_b2_y(i_b2_y),
    .i_b1_valid(i_b1_valid), .i_b2_valid(i_b2_valid),
    .o_p1_x(o_p1_x), .o_p2_x(o_p2_x), .o_p1_y(o_p1_y), .o_p2_y(o_p2_y),
    .o_p1_hp(o_p1_hp), .o_p2_hp(o_p2_hp),
    .o_p1_shield(o_p1_shield), .o_p1_squat(o_p1_squat),
    .o_p2_shield(o_p2_shield), .o_p2_squat(o_p2_squat),
    .o_b1_x(o_b1_x), .o_b2_x(o_b2_x), .o_b1_y(o_b1_y), .o_b2_y(o_b2_y),
    .o_b1_valid(o_b1_valid), .o_b2_valid(o_b2_valid),
    .o_is_gaming(o_is_gaming), .o_game_state(o_game_state),
    .o_round_start(o_round_start), .o_frame_cnt(o_frame_cnt)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_frame();
    i_frame_start = 1'b1;
    tick(1);
    i_frame_start = 1'b0;
  endtask

  task automatic press_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_frame_start = 1'b0; i_start = 1'b0;
    i_p1_x = '0; i_p2_x = '0; i_p1_y = '0; i_p2_y = '0;
    i_p1_hp = '0; i_p2_hp = '0;
    i_p1_shield = 1'b0; i_p1_squat = 1'b0; i_p2_shield = 1'b0; i_p2_squat = 1'b0;
    i_b1_x = '0; i_b2_x = '0; i_b1_y = '0; i_b2_y = '0;
    i_b1_valid = 1'b0; i_b2_valid = 1'b0;
    tick(2);
    chk("rst_state", o_game_state, 0);
    chk("rst_gaming", o_is_gaming, 0);
    chk("rst_round_start", o_round_start, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    i_rst_n = 1'b1;

    // IDLE snapshots live inputs only at the frame pulse
    i_p1_x = 10'sd25; i_p2_hp = 4'd5; i_p1_hp = 4'd5; i_p1_squat = 1'b1; i_b1_y = -9'sd3;
    tick(3);
    chk("pre_pulse_p1_x", o_p1_x, 0);
    chk("pre_pulse_state", o_game_state, 0);
    pulse_frame();
    chk("idle_p1_x", o_p1_x, 25);
    chk("idle_p2_hp", o_p2_hp, 5);
    chk("idle_p1_squat", o_p1_squat, 1);
    chk("idle_b1_y", o_b1_y, -3);
    chk("idle_state", o_game_state, 0);
    chk("idle_gaming", o_is_gaming, 0);
    chk("idle_fcnt1", o_frame_cnt, 1);
    tick(2); pulse_frame(); tick(2); pulse_frame();
    chk("idle_fcnt3", o_frame_cnt, 3);

    // start latched well before the frame pulse
    press_start();
    tick(100);
    chk("pending_no_commit", o_game_state, 0);
    i_p1_x = 10'sd10; i_p2_x = -10'sd7; i_b1_valid = 1'b1;
    pulse_frame();
    chk("start_round_pulse", o_round_start, 1);
    chk("start_state", o_game_state, 1);
    chk("start_gaming", o_is_gaming, 1);
    chk("start_fcnt", o_frame_cnt, 0);
    chk("start_b1_valid", o_b1_valid, 1);
    chk("start_p2_x_neg", o_p2_x, -7);
    tick(1);
    chk("round_pulse_one_cycle", o_round_start, 0);

    // mid-frame change is held until next pulse; start in GAMING ignored
    i_p1_x = 10'sd40;
    press_start();
    tick(3);
    chk("midframe_hold", o_p1_x, 10);
    pulse_frame();
    chk("midframe_update", o_p1_x, 40);
    chk("gaming_fcnt", o_frame_cnt, 1);
    chk("gaming_stays", o_game_state, 1);

    // both hp zero -> LOSE, bullets suppressed
    i_p1_hp = 4'd0; i_p2_hp = 4'd0;
    tick(2);
    pulse_frame();
    chk("lose_state", o_game_state, 3);
    chk("lose_b1_valid", o_b1_valid, 0);
    chk("lose_fcnt", o_frame_cnt, 0);
    chk("lose_gaming", o_is_gaming, 0);
    chk("lose_no_round_pulse", o_round_start, 0);

    // hold period: start held at cnt 2 and 3 is ignored; accepted at cnt 4
    pulse_frame(); tick(1); pulse_frame();
    chk("lose_fcnt2", o_frame_cnt, 2);
    i_start = 1'b1;
    tick(1);
    pulse_frame();
    chk("lose_hold_cnt2", o_game_state, 3);
    pulse_frame();
    chk("lose_hold_cnt3", o_game_state, 3);
    chk("lose_fcnt4", o_frame_cnt, 4);
    pulse_frame();
    chk("lose_exit", o_game_state, 0);
    chk("lose_exit_fcnt", o_frame_cnt, 0);
    i_start = 1'b0;
    tick(2);
    pulse_frame();
    chk("no_stale_pending", o_game_state, 0);

    // new round ending in WIN
    i_p1_hp = 4'd3; i_p2_hp = 4'd3;
    press_start();
    pulse_frame();
    chk("round2_state", o_game_state, 1);
    i_p2_hp = 4'd0; i_b2_valid = 1'b1; i_p2_shield = 1'b1;
    pulse_frame();
    chk("win_state", o_game_state, 2);
    chk("win_b2_valid", o_b2_valid, 0);
    chk("win_p2_shield", o_p2_shield, 1);
    pulse_frame(); pulse_frame();
    chk("win_fcnt2", o_frame_cnt, 2);
    press_start();
    pulse_frame();
    chk("win_early_start_ignored", o_game_state, 2);
    pulse_frame();
    chk("win_fcnt4", o_frame_cnt, 4);
    chk("win_still_held", o_game_state, 2);
    i_start = 1'b1;
    tick(1);
    pulse_frame();
    chk("win_exit", o_game_state, 0);
    i_start = 1'b0;

    // frame counter saturates at all-ones in IDLE
    for (int k = 0; k < 260; k++) pulse_frame();
    chk("fcnt_saturate", o_frame_cnt, 255);

    // async reset mid-round, no frame pulse
    i_p1_hp = 4'd2; i_p2_hp = 4'd2;
    press_start();
    pulse_frame();
    chk("round3_state", o_game_state, 1);
    tick(3);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_state", o_game_state, 0);
    chk("async_rst_gaming", o_is_gaming, 0);
    chk("async_rst_p1_x", o_p1_x, 0);
    chk("async_rst_b1_valid", o_b1_valid, 0);
    chk("async_rst_fcnt", o_frame_cnt, 0);
    tick(1);
    i_rst_n = 1'b1;
    tick(1);

    // pending start is discarded by reset
    press_start();
    i_rst_n = 1'b0;
    tick(1);
    i_rst_n = 1'b1;
    tick(1);
    pulse_frame();
    chk("rst_clears_pending", o_game_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
